// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and the parity helper for the UART.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int DATA_BITS_MAX = 9;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Parity bit that makes data plus parity odd (mode ODD) or even (mode EVEN).
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-time down-counter; expire pulses for one cycle, load_val cycles after a load.
module uart_bit_timer #(
  parameter  int BAUD_DIVIDER = 104,
  localparam int TMR_W        = $clog2(BAUD_DIVIDER) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Counter parks at zero, so the final count of one is seen for exactly one cycle.
  assign expire = (count_q == TMR_W'(1));

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART with independent TX and RX bit timing.
// Optional rx_break output when UART_BREAK_DETECT_EN is defined.
//
// state  | meaning (TX and RX FSMs share the encoding)
// IDLE   | line idle; TX waits for tx_send, RX waits for rxs low
// START  | start bit; RX checks it again at its centre
// DATA   | data bits, LSB first, tx_idx/rx_idx counting up
// PARITY | parity bit (never entered when PARITY is none)
// STOP   | stop bit(s); RX reports the frame after the last one
module uart_txrx
  import uart_pkg::*;
#(
  parameter int BAUD_DIVIDER = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_send,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
`ifdef UART_BREAK_DETECT_EN
  ,
  output logic                 rx_break
`endif
);

  localparam int               TMR_W      = $clog2(BAUD_DIVIDER) + 1;
  localparam int               IDX_W      = $clog2(DATA_BITS + 1);
  localparam logic [TMR_W-1:0] BIT_TICKS  = TMR_W'(BAUD_DIVIDER);
  localparam logic [TMR_W-1:0] HALF_TICKS = TMR_W'(BAUD_DIVIDER / 2);
  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != PARITY_NONE);

  tx_state_e            tx_state_q, tx_state_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_tmr_load, tx_tmr_exp;

  uart_bit_timer #(.BAUD_DIVIDER(BAUD_DIVIDER)) u_tx_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tx_tmr_load),
    .load_val (BIT_TICKS),
    .expire   (tx_tmr_exp)
  );

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_idx_d    = tx_idx_q;
    tx_tmr_load = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_send) begin
          tx_shift_d  = tx_data;
          tx_par_d    = parity_bit(DATA_BITS_MAX'(tx_data), PARITY);
          tx_d        = 1'b0;
          tx_busy_d   = 1'b1;
          tx_tmr_load = 1'b1;
          tx_state_d  = TX_START;
        end
      end
      TX_START: begin
        if (tx_tmr_exp) begin
          tx_d        = tx_shift_q[0];
          tx_shift_d  = tx_shift_q >> 1;
          tx_idx_d    = '0;
          tx_tmr_load = 1'b1;
          tx_state_d  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tmr_exp) begin
          tx_tmr_load = 1'b1;
          if (tx_idx_q == LAST_DATA) begin
            tx_idx_d = '0;
            if (HAS_PARITY) begin
              tx_d       = tx_par_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_tmr_exp) begin
          tx_d        = 1'b1;
          tx_idx_d    = '0;
          tx_tmr_load = 1'b1;
          tx_state_d  = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tmr_exp) begin
          if (tx_idx_q == LAST_STOP) begin
            tx_busy_d  = 1'b0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_idx_d    = tx_idx_q + 1'b1;
            tx_tmr_load = 1'b1;
          end
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_busy_d  = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_idx_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  // Receiver: rx is asynchronous, so only the twice-registered rxs_q is used.
  logic                 rx_meta_q, rxs_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic                 rx_par_q, rx_par_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_break_q, rx_break_d;
  logic                 ferr_now;
  logic                 rx_tmr_load, rx_tmr_exp;
  logic [TMR_W-1:0]     rx_tmr_val;

  uart_bit_timer #(.BAUD_DIVIDER(BAUD_DIVIDER)) u_rx_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (rx_tmr_load),
    .load_val (rx_tmr_val),
    .expire   (rx_tmr_exp)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_idx_d    = rx_idx_q;
    rx_par_d    = rx_par_q;
    ferr_acc_d  = ferr_acc_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    rx_break_d  = rx_break_q;
    rx_tmr_load = 1'b0;
    rx_tmr_val  = BIT_TICKS;
    ferr_now    = ferr_acc_q | ~rxs_q;
    case (rx_state_q)
      RX_IDLE: begin
`ifdef UART_BREAK_DETECT_EN
        // Hold off while in break; any low sample restarts the high-time bit window.
        if (rx_break_q) begin
          if (!rxs_q) begin
            rx_tmr_load = 1'b1;
          end else if (rx_tmr_exp) begin
            rx_break_d = 1'b0;
          end
        end else
`endif
        if (!rxs_q) begin
          rx_tmr_load = 1'b1;
          rx_tmr_val  = HALF_TICKS;
          rx_state_d  = RX_START;
        end
      end
      RX_START: begin
        if (rx_tmr_exp) begin
          if (!rxs_q) begin
            rx_idx_d    = '0;
            rx_tmr_load = 1'b1;
            rx_state_d  = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_tmr_exp) begin
          rx_shift_d  = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
          rx_tmr_load = 1'b1;
          if (rx_idx_q == LAST_DATA) begin
            rx_idx_d   = '0;
            ferr_acc_d = 1'b0;
            rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_tmr_exp) begin
          rx_par_d    = rxs_q;
          rx_idx_d    = '0;
          ferr_acc_d  = 1'b0;
          rx_tmr_load = 1'b1;
          rx_state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tmr_exp) begin
          if (rx_idx_q == LAST_STOP) begin
            rx_state_d = RX_IDLE;
`ifdef UART_BREAK_DETECT_EN
            if (ferr_now && (rx_shift_q == '0)) begin
              rx_break_d  = 1'b1;
              rx_tmr_load = 1'b1;
            end else
`endif
            begin
              rx_data_d  = rx_shift_q;
              perr_d     = HAS_PARITY &&
                           (parity_bit(DATA_BITS_MAX'(rx_shift_q), PARITY) != rx_par_q);
              ferr_d     = ferr_now;
              rx_valid_d = 1'b1;
            end
          end else begin
            ferr_acc_d  = ferr_now;
            rx_idx_d    = rx_idx_q + 1'b1;
            rx_tmr_load = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_idx_q   <= '0;
      rx_par_q   <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_break_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_idx_q   <= rx_idx_d;
      rx_par_q   <= rx_par_d;
      ferr_acc_q <= ferr_acc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rx_break_q <= rx_break_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
`ifdef UART_BREAK_DETECT_EN
  assign rx_break      = rx_break_q;
`else
  logic unused_break;
  assign unused_break = rx_break_q;
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: an 8N1 instance and an 8E1 instance, both at 4 clk per bit.
module tb_uart_txrx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data_n, tx_data_e;
  logic       tx_send_n, tx_send_e;
  logic       tx_n, tx_e, busy_n, busy_e;
  logic       rx_n, rx_e, rx_n_drv, rx_e_drv, loop_n, loop_e;
  logic [7:0] rx_data_n, rx_data_e;
  logic       valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e;
`ifdef UART_BREAK_DETECT_EN
  logic       break_n, break_e;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int vcnt_n = 0;
  int vcnt_e = 0;

  always #5 clk = ~clk;

  assign rx_n = loop_n ? tx_n : rx_n_drv;
  assign rx_e = loop_e ? tx_e : rx_e_drv;

  uart_txrx #(.BAUD_DIVIDER(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_n (
    .clk(clk), .rstn(rstn), .tx_data(tx_data_n), .tx_send(tx_send_n), .tx(tx_n),
    .tx_busy(busy_n), .rx(rx_n), .rx_data(rx_data_n), .rx_valid(valid_n),
    .rx_parity_err(perr_n), .rx_frame_err(ferr_n)
`ifdef UART_BREAK_DETECT_EN
    , .rx_break(break_n)
`endif
  );

  uart_txrx #(.BAUD_DIVIDER(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_e (
    .clk(clk), .rstn(rstn), .tx_data(tx_data_e), .tx_send(tx_send_e), .tx(tx_e),
    .tx_busy(busy_e), .rx(rx_e), .rx_data(rx_data_e), .rx_valid(valid_e),
    .rx_parity_err(perr_e), .rx_frame_err(ferr_e)
`ifdef UART_BREAK_DETECT_EN
    , .rx_break(break_e)
`endif
  );

  always @(posedge clk) begin
    if (valid_n) vcnt_n <= vcnt_n + 1;
    if (valid_e) vcnt_e <= vcnt_e + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Called one step after the start edge; walks the 8N1 frame cycle by cycle.
  task automatic chk_tx_frame(input logic [7:0] d, input logic keep_send);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) begin
      if (i == 2)  tx_send_n = keep_send;
      if (i == 20) tx_send_n = 1'b1;
      if (i == 21) tx_send_n = keep_send;
      chk($sformatf("tx_bit%0d_%02h", i / 4, d), tx_n, fr[i/4]);
      chk($sformatf("tx_busy_c%0d", i), busy_n, 1'b1);
      tick();
    end
  endtask

  task automatic drive_rx(input logic to_e, input logic [7:0] d, input logic par_inv,
                          input logic stop_val);
    logic [10:0] fr;
    int nbits;
    if (to_e) begin
      fr    = {stop_val, (^d) ^ par_inv, d, 1'b0};
      nbits = 11;
    end else begin
      fr    = {1'b1, stop_val, d, 1'b0};
      nbits = 10;
    end
    for (int i = 0; i < nbits; i++) begin
      if (to_e) rx_e_drv = fr[i];
      else      rx_n_drv = fr[i];
      ticks(4);
    end
    rx_e_drv = 1'b1;
    rx_n_drv = 1'b1;
    ticks(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int t;
    rstn = 1'b0;
    tx_data_n = '0; tx_data_e = '0; tx_send_n = 1'b0; tx_send_e = 1'b0;
    rx_n_drv = 1'b1; rx_e_drv = 1'b1; loop_n = 1'b0; loop_e = 1'b0;
    ticks(3);
    chk("rst_tx", tx_n, 1'b1);
    chk("rst_busy", busy_n, 1'b0);
    chk("rst_rx_data", rx_data_n, 8'h00);
    chk("rst_rx_valid", valid_n, 1'b0);
    chk("rst_perr", perr_e, 1'b0);
    chk("rst_ferr", ferr_n, 1'b0);
    rstn = 1'b1;
    ticks(2);

    // Single 8N1 frame of 0xA5, with a mid-frame tx_send pulse that must be ignored.
    tx_data_n = 8'hA5; tx_send_n = 1'b1;
    tick();
    chk_tx_frame(8'hA5, 1'b0);
    chk("a5_busy_end", busy_n, 1'b0);
    chk("a5_tx_end", tx_n, 1'b1);
    ticks(3);

    // tx_send held high: back-to-back frames with one idle cycle between.
    tx_data_n = 8'h3C; tx_send_n = 1'b1;
    tick();
    tx_data_n = 8'hC3;
    chk_tx_frame(8'h3C, 1'b1);
    chk("gap_busy", busy_n, 1'b0);
    chk("gap_tx", tx_n, 1'b1);
    tick();
    chk_tx_frame(8'hC3, 1'b0);
    for (int i = 0; i < 4; i++) chk("no_queue_busy", busy_n, 1'b0);
    ticks(4);
    chk("no_queue_busy_late", busy_n, 1'b0);

    // Loopback sweep on the even-parity instance.
    loop_e = 1'b1;
    v0 = vcnt_e;
    for (int w = 0; w < 256; w++) begin
      tx_data_e = w[7:0]; tx_send_e = 1'b1;
      tick();
      tx_send_e = 1'b0;
      t = 0;
      while (busy_e && t < 100) begin
        tick();
        t++;
      end
      chk("loop_tx_done", busy_e, 1'b0);
      ticks(2);
      chk($sformatf("loop_cnt_%02h", w), vcnt_e, v0 + w + 1);
      chk($sformatf("loop_data_%02h", w), rx_data_e, w[7:0]);
      chk($sformatf("loop_perr_%02h", w), perr_e, 1'b0);
    end
    chk("loop_total", vcnt_e, v0 + 256);
    chk("loop_ferr", ferr_e, 1'b0);
    loop_e = 1'b0;
    ticks(4);

    // Injected errors: inverted parity, then a low stop bit.
    v0 = vcnt_e;
    drive_rx(1'b1, 8'h55, 1'b1, 1'b1);
    chk("perr_cnt", vcnt_e, v0 + 1);
    chk("perr_data", rx_data_e, 8'h55);
    chk("perr_flag", perr_e, 1'b1);
    chk("perr_ferr", ferr_e, 1'b0);
    drive_rx(1'b1, 8'h55, 1'b0, 1'b0);
    chk("ferr_cnt", vcnt_e, v0 + 2);
    chk("ferr_data", rx_data_e, 8'h55);
    chk("ferr_perr", perr_e, 1'b0);
    chk("ferr_flag", ferr_e, 1'b1);

    // One-cycle glitch while idle, then a good 0x12 frame straight after.
    v0 = vcnt_n;
    rx_n_drv = 1'b0;
    tick();
    rx_n_drv = 1'b1;
    ticks(2);
    drive_rx(1'b0, 8'h12, 1'b0, 1'b1);
    chk("glitch_cnt", vcnt_n, v0 + 1);
    chk("glitch_data", rx_data_n, 8'h12);
    chk("glitch_ferr", ferr_n, 1'b0);
    chk("glitch_perr", perr_n, 1'b0);

    // Reset mid-TX and mid-RX.
    tx_data_n = 8'hF0; tx_send_n = 1'b1;
    tick();
    tx_send_n = 1'b0;
    rx_n_drv = 1'b0; ticks(4);
    rx_n_drv = 1'b1; ticks(4);
    rx_n_drv = 1'b0; ticks(4);
    v0 = vcnt_n;
    rstn = 1'b0;
    #1;
    chk("mid_rst_tx", tx_n, 1'b1);
    chk("mid_rst_busy", busy_n, 1'b0);
    rx_n_drv = 1'b1;
    ticks(3);
    rstn = 1'b1;
    ticks(50);
    chk("post_rst_no_valid", vcnt_n, v0);
    chk("post_rst_tx", tx_n, 1'b1);
    chk("post_rst_busy", busy_n, 1'b0);

    loop_n = 1'b1;
    tx_data_n = 8'h81; tx_send_n = 1'b1;
    tick();
    chk_tx_frame(8'h81, 1'b0);
    ticks(2);
    chk("post_rst_rx_cnt", vcnt_n, v0 + 1);
    chk("post_rst_rx_data", rx_data_n, 8'h81);
    chk("post_rst_rx_ferr", ferr_n, 1'b0);
    loop_n = 1'b0;
    ticks(4);

`ifdef UART_BREAK_DETECT_EN
    v0 = vcnt_n;
    rx_n_drv = 1'b0;
    ticks(48);
    chk("break_set", break_n, 1'b1);
    chk("break_no_valid", vcnt_n, v0);
    rx_n_drv = 1'b1;
    ticks(10);
    chk("break_clear", break_n, 1'b0);
    chk("break_no_valid_end", vcnt_n, v0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
